sevenseg_scanner: RTL

Time-multiplexing scanner between the Wishbone seven-segment register and the board's shared segment bus. It consumes eight 7-bit segment patterns plus a digit mask and drives one common set of segment lines with active-low per-digit anode enables. Each digit occupies a fixed time slot that starts with an anti-ghosting blank interval. Inputs are shadow-latched once per frame so a mid-frame register write never tears the display.

---
 rtl/sevenseg_scanner.sv | 99 +++++++++
 1 files changed

// File: rtl/sevenseg_scanner.sv
// Time-multiplexed seven-segment scanner with per-frame shadow latching.
// Optional PWM dimming is compiled in with `define SEVENSEG_DIM_EN.
module sevenseg_scanner #(
   parameter int CLK_DIV      = 50000,
   parameter int BLANK_CYCLES = 500,
   parameter int NUM_DIGITS   = 8
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [55:0] i_segments,
   input  logic [7:0]  i_digit_mask,
   input  logic [3:0]  i_brightness,
   output logic [6:0]  o_seg,
   output logic [7:0]  o_an,
   output logic        o_frame_start
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
   localparam logic [2:0]    DIG_LAST  = 3'(NUM_DIGITS - 1);

   typedef enum logic {PH_BLANK, PH_ON} phase_t;

   logic [CW-1:0] cnt, cnt_next;
   logic [2:0]    dig, dig_next;
   logic [55:0]   sh_seg, seg_src;
   logic [7:0]    sh_mask, mask_src;
   logic          load, gate, frame_next;
   logic [7:0]    an_next;
   logic [6:0]    seg_next;
   phase_t        phase;

`ifdef SEVENSEG_DIM_EN
   logic [3:0]    sh_bri, bri_src;
   logic [CW+3:0] cnt_wide;
`else
   logic          unused_bri;
   assign unused_bri = ^i_brightness;
`endif

   always_comb begin
      load       = (cnt == '0) && (dig == '0);
      phase      = (cnt < BLANK_END) ? PH_BLANK : PH_ON;
      cnt_next   = cnt + 1'b1;
      dig_next   = dig;
      if (cnt == CNT_LAST) begin
         cnt_next = '0;
         dig_next = (dig == DIG_LAST) ? '0 : dig + 3'd1;
      end
      // Outputs for the load cycle use the incoming values so digit 0 shows fresh data.
      seg_src    = load ? i_segments   : sh_seg;
      mask_src   = load ? i_digit_mask : sh_mask;
`ifdef SEVENSEG_DIM_EN
      bri_src    = load ? i_brightness : sh_bri;
      cnt_wide   = {4'b0000, cnt};
      gate       = (cnt_wide[3:0] <= bri_src);
`else
      gate       = 1'b1;
`endif
      an_next    = '1;
      if (phase == PH_ON && mask_src[dig] && gate)
         an_next[dig] = 1'b0;
      seg_next   = '1;
      for (int unsigned n = 0; n < 8; n++)
         if (dig == 3'(n))
            seg_next = seg_src[7*n +: 7];
      frame_next = (cnt == CW'(1)) && (dig == '0);
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         cnt           <= '0;
         dig           <= '0;
         sh_seg        <= '0;
         sh_mask       <= '0;
`ifdef SEVENSEG_DIM_EN
         sh_bri        <= '0;
`endif
         o_an          <= '1;
         o_seg         <= '1;
         o_frame_start <= 1'b0;
      end else begin
         cnt           <= cnt_next;
         dig           <= dig_next;
         if (load) begin
            sh_seg  <= i_segments;
            sh_mask <= i_digit_mask;
`ifdef SEVENSEG_DIM_EN
            sh_bri  <= i_brightness;
`endif
         end
         o_an          <= an_next;
         o_seg         <= seg_next;
         o_frame_start <= frame_next;
      end
   end

endmodule
